// File: rtl/light_phase_scheduler.sv
// -----------------------------------------------------------------------------
// light_phase_scheduler
//   Four-approach traffic light sequencer: ALLRED -> GREEN -> YELLOW -> ALLRED.
//   All timing is in "ticks" of a TICK_DIV-cycle prescaler. The prescaler and
//   the elapsed-tick counter restart on every state change, so each interval is
//   an exact multiple of TICK_DIV cycles. Approaches are served round-robin.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   req    : level requests, [0]=N [1]=E [2]=S [3]=W
//   grant  : one-hot approach being served (GREEN/YELLOW), 0 in ALLRED
//   green  : green lamps (grant while GREEN)
//   yellow : yellow lamps (grant while YELLOW)
//   red    : ~(green | yellow)
//   phase  : 0=ALLRED, 1=GREEN, 2=YELLOW
// -----------------------------------------------------------------------------
module light_phase_scheduler #(
    parameter int TICK_DIV = 4,
    parameter int ALLRED_T = 1,
    parameter int MIN_GREEN = 2,
    parameter int GREEN_T  = 6,
    parameter int YELLOW_T = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    localparam logic [3:0] TICK_MAX = 4'(TICK_DIV - 1);
    localparam logic [3:0] ALLRED_N = 4'(ALLRED_T);
    localparam logic [3:0] MING_N   = 4'(MIN_GREEN);
    localparam logic [3:0] GREEN_N  = 4'(GREEN_T);
    localparam logic [3:0] YELLOW_N = 4'(YELLOW_T);

    state_t     state_q, state_d;
    logic [3:0] presc_q;
    logic [3:0] n_q, n_next;
    logic [3:0] grant_q, grant_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gidx;
    logic [1:0] idx;
    logic [3:0] winner;
    logic       found;
    logic       tick;

    assign tick   = (presc_q == TICK_MAX);
    // Count including the current tick edge, saturating at 15.
    assign n_next = (n_q == 4'd15) ? 4'd15 : n_q + 4'd1;

    // Index of the approach currently granted.
    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (grant_q[i]) gidx = 2'(i);
    end

    // Round-robin: first requesting approach at or after ptr, wrapping.
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Next-state logic; every transition is qualified by a tick edge.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (tick) begin
            unique case (state_q)
                ALLRED: begin
                    if (n_next >= ALLRED_N && found) begin
                        state_d = GREEN;
                        grant_d = winner;
                    end
                end
                GREEN: begin
                    if ((n_next >= MING_N && (req & grant_q) == 4'd0) ||
                        (n_next >= GREEN_N && (req & ~grant_q) != 4'd0))
                        state_d = YELLOW;
                end
                YELLOW: begin
                    if (n_next == YELLOW_N) begin
                        state_d = ALLRED;
                        grant_d = 4'd0;
                        ptr_d   = gidx + 2'd1;
                    end
                end
                default: begin
                    state_d = ALLRED;
                    grant_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALLRED;
            presc_q <= 4'd0;
            n_q     <= 4'd0;
            grant_q <= 4'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            if (state_d != state_q) begin
                presc_q <= 4'd0;
                n_q     <= 4'd0;
            end else if (tick) begin
                presc_q <= 4'd0;
                n_q     <= n_next;
            end else begin
                presc_q <= presc_q + 4'd1;
            end
        end
    end

    // Moore outputs from registered state only.
    assign grant  = grant_q;
    assign green  = (state_q == GREEN)  ? grant_q : 4'd0;
    assign yellow = (state_q == YELLOW) ? grant_q : 4'd0;
    assign red    = ~(green | yellow);
    assign phase  = state_q;

endmodule

// File: tb/tb_light_phase_scheduler.sv
module tb_light_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant, green, yellow, red;
    logic [1:0] phase;

    int n_cmp = 0;
    int n_err = 0;

    light_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .green (green),
        .yellow(yellow),
        .red   (red),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance k rising edges, sampling at the falling edge after each one and
    // checking the lamp invariants every cycle.
    task automatic wait_pos(input int k);
        logic [3:0] exp_red;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
            exp_red = ~(green | yellow);
            chk("inv_red", {4'd0, red}, {4'd0, exp_red});
            chk("inv_onehot", 8'($onehot0(green | yellow)), 8'd1);
        end
    endtask

    task automatic do_reset(input logic [3:0] r);
        reset = 1'b1;
        req   = r;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [0:4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset state
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        chk("rst_grant", {4'd0, grant}, 8'h00);
        chk("rst_red",   {4'd0, red},   8'h0f);
        chk("rst_phase", {6'd0, phase}, 8'h00);

        // Single requester rests in green indefinitely
        do_reset(4'b0001);
        wait_pos(3);
        chk("rest_allred", {6'd0, phase}, 8'h00);
        wait_pos(1);
        chk("rest_green", {4'd0, green}, 8'h01);
        for (int i = 0; i < 200; i++) begin
            wait_pos(1);
            chk("rest_phase",  {6'd0, phase},  8'h01);
            chk("rest_yellow", {4'd0, yellow}, 8'h00);
        end

        // Competing W request: 24 green, 8 yellow, 4 allred, then W
        do_reset(4'b0001);
        wait_pos(4);
        chk("comp_green_n", {4'd0, green}, 8'h01);
        req = 4'b1001;
        wait_pos(23);
        chk("comp_green_end", {6'd0, phase}, 8'h01);
        wait_pos(1);
        chk("comp_yellow", {4'd0, yellow}, 8'h01);
        wait_pos(7);
        chk("comp_yellow_end", {6'd0, phase}, 8'h02);
        wait_pos(1);
        chk("comp_allred", {6'd0, phase}, 8'h00);
        chk("comp_allred_g", {4'd0, grant}, 8'h00);
        wait_pos(3);
        chk("comp_allred_end", {6'd0, phase}, 8'h00);
        wait_pos(1);
        chk("comp_green_w", {4'd0, green}, 8'h08);

        // Request dropped in green cycle 2: min green 8 cycles, then idle allred
        do_reset(4'b0001);
        wait_pos(4);
        chk("drop_green", {4'd0, green}, 8'h01);
        wait_pos(1);
        req = 4'b0000;
        wait_pos(6);
        chk("drop_green_end", {6'd0, phase}, 8'h01);
        wait_pos(1);
        chk("drop_yellow", {4'd0, yellow}, 8'h01);
        wait_pos(7);
        chk("drop_yellow_end", {6'd0, phase}, 8'h02);
        wait_pos(1);
        chk("drop_allred", {6'd0, phase}, 8'h00);
        wait_pos(40);
        chk("drop_idle_phase", {6'd0, phase}, 8'h00);
        chk("drop_idle_grant", {4'd0, grant}, 8'h00);

        // Requests present only between tick edges are ignored
        do_reset(4'b0000);
        for (int k = 0; k < 4; k++) begin
            wait_pos(1);
            req = 4'b1111;
            wait_pos(2);
            req = 4'b0000;
            chk("glitch_mid", {6'd0, phase}, 8'h00);
            wait_pos(1);
            chk("glitch_tick_phase", {6'd0, phase}, 8'h00);
            chk("glitch_tick_grant", {4'd0, grant}, 8'h00);
        end

        // Round-robin with all requests: N,E,S,W,N on a 36-cycle period
        do_reset(4'b1111);
        wait_pos(3);
        chk("rr_first_allred", {6'd0, phase}, 8'h00);
        wait_pos(1);
        chk("rr_green0", {4'd0, green}, {4'd0, seq[0]});
        for (int k = 1; k < 5; k++) begin
            wait_pos(24);
            chk("rr_yellow", {4'd0, yellow}, {4'd0, seq[k-1]});
            wait_pos(8);
            chk("rr_allred", {6'd0, phase}, 8'h00);
            wait_pos(3);
            chk("rr_allred_end", {6'd0, phase}, 8'h00);
            wait_pos(1);
            chk("rr_green", {4'd0, green}, {4'd0, seq[k]});
        end

        // Reset asserted mid-yellow of E
        do_reset(4'b1111);
        wait_pos(40);
        chk("mid_green_e", {4'd0, green}, 8'h02);
        wait_pos(24);
        chk("mid_yellow_e", {4'd0, yellow}, 8'h02);
        wait_pos(2);
        reset = 1'b1;
        #1;
        chk("async_phase",  {6'd0, phase},  8'h00);
        chk("async_red",    {4'd0, red},    8'h0f);
        chk("async_grant",  {4'd0, grant},  8'h00);
        chk("async_yellow", {4'd0, yellow}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        wait_pos(3);
        chk("post_rst_allred", {6'd0, phase}, 8'h00);
        wait_pos(1);
        chk("post_rst_grant_n", {4'd0, grant}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
